// File: rtl/sa_operand_loader.sv
// Operand feeder for systolic_array_wrapper: reads A and B from two SRAMs and streams them in array order.
// Optional macro SA_LOADER_B2B_EN queues a start seen during DRAIN so the next load follows DONE directly.
module sa_operand_loader #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int AW        = 5,
    parameter int BASE_A    = 0,
    parameter int BASE_B    = 0,
    parameter int DRAIN_CYC = 35
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          a_rd_en,
    output logic [AW-1:0] a_rd_addr,
    input  logic [DW-1:0] a_rd_data,
    output logic          b_rd_en,
    output logic [AW-1:0] b_rd_addr,
    input  logic [DW-1:0] b_rd_data,
    output logic          sa_en,
    output logic [DW-1:0] shift_in_A,
    output logic [DW-1:0] shift_in_B
);

    localparam int NN  = N * N;
    localparam int BW  = $clog2(NN) + 1;
    localparam int DCW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [BW-1:0]  beat;
    logic [DCW-1:0] drain_cnt;
    logic           rd_en;
    logic           data_vld;
    logic           last_beat;
    logic           drain_last;
    logic           tail_empty;
    int             row;
    int             col;
    int             a_word;
    int             b_word;

`ifdef SA_LOADER_B2B_EN
    logic           pending;
`endif

    assign last_beat  = (beat == BW'(NN - 1));
    assign drain_last = (drain_cnt == DCW'(DRAIN_CYC - 1));
    // The drain window only opens once the two-stage read pipeline has emptied.
    assign tail_empty = !data_vld && !sa_en;
    assign a_rd_en    = rd_en;
    assign b_rd_en    = rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (tail_empty && drain_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
`ifdef SA_LOADER_B2B_EN
                if (pending) begin
                    state_nxt = READ;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat      <= '0;
            drain_cnt <= '0;
        end else begin
            beat      <= (state == READ) ? beat + 1'b1 : '0;
            drain_cnt <= (state == DRAIN && tail_empty) ? drain_cnt + 1'b1 : '0;
        end
    end

    // Beat k = row*N + col walks A's row right-to-left and B's column bottom-to-top.
    always_comb begin
        row       = int'(beat) / N;
        col       = int'(beat) % N;
        a_word    = BASE_A + row * N + (N - 1 - col);
        b_word    = BASE_B + (N - 1 - col) * N + row;
        a_rd_addr = '0;
        b_rd_addr = '0;
        if (rd_en) begin
            a_rd_addr = AW'(a_word);
            b_rd_addr = AW'(b_word);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_vld   <= 1'b0;
            sa_en      <= 1'b0;
            shift_in_A <= '0;
            shift_in_B <= '0;
        end else begin
            data_vld   <= rd_en;
            sa_en      <= data_vld;
            shift_in_A <= data_vld ? a_rd_data : '0;
            shift_in_B <= data_vld ? b_rd_data : '0;
        end
    end

`ifdef SA_LOADER_B2B_EN
    // Repeated starts during DRAIN collapse into a single queued load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (state == DONE) begin
            pending <= 1'b0;
        end else if (state == DRAIN && start) begin
            pending <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_operand_loader.sv
// Scoreboard bench for sa_operand_loader: random operand matrices, a cycle timeline model and a stream queue.
// Also exercises the SA_LOADER_B2B_EN build when that macro is defined.
module tb_sa_operand_loader;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int AW        = 6;
    localparam int BASE_A    = 16;
    localparam int BASE_B    = 7;
    localparam int DRAIN_CYC = 35;
    localparam int NN        = N * N;
    localparam int DONECYC   = NN + 2 + DRAIN_CYC;
    localparam int LOADLEN   = DONECYC + 1;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          a_rd_en;
    logic [AW-1:0] a_rd_addr;
    logic [DW-1:0] a_rd_data = '0;
    logic          b_rd_en;
    logic [AW-1:0] b_rd_addr;
    logic [DW-1:0] b_rd_data = '0;
    logic          sa_en;
    logic [DW-1:0] shift_in_A;
    logic [DW-1:0] shift_in_B;

    logic [DW-1:0] memA [2**AW];
    logic [DW-1:0] memB [2**AW];
    logic [DW-1:0] matA [N][N];
    logic [DW-1:0] matB [N][N];
    beat_t         expQ [$];
    beat_t         expBeat;

    int checks    = 0;
    int errors    = 0;
    int edgeCnt   = 0;
    int curEdge   = -1;
    int nextEdge  = -1;
    int lastStart = -1000;
    int cyc;

    sa_operand_loader #(
        .N(N), .DW(DW), .AW(AW), .BASE_A(BASE_A), .BASE_B(BASE_B), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .sa_en(sa_en), .shift_in_A(shift_in_A), .shift_in_B(shift_in_B)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    // Synchronous-read SRAM models with one cycle of latency.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= memA[a_rd_addr];
        if (b_rd_en) b_rd_data <= memB[b_rd_addr];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edgeCnt);
        end
    endtask

    task automatic fillMatrices(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                matA[i][j] = (mode == 1) ? DW'(j + 1) : DW'($urandom);
                matB[i][j] = (mode == 1) ? DW'(i + 1) : DW'($urandom);
                memA[BASE_A + i * N + j] = matA[i][j];
                memB[BASE_B + i * N + j] = matB[i][j];
            end
        end
    endtask

    // Row i of A right-to-left paired with column i of B bottom-to-top.
    task automatic pushExpected();
        for (int i = 0; i < N; i++) begin
            for (int j = N - 1; j >= 0; j--) begin
                expQ.push_back('{matA[i][j], matB[j][i]});
            end
        end
    endtask

    task automatic waitIdle();
        @(negedge clk);
        while (edgeCnt < lastStart + LOADLEN) @(negedge clk);
    endtask

    task automatic waitCycle(input int c);
        while (edgeCnt < lastStart + c) @(negedge clk);
    endtask

    task automatic applyStimulus(input int mode);
        waitIdle();
        fillMatrices(mode);
        pushExpected();
        start     = 1'b1;
        nextEdge  = edgeCnt + 1;
        lastStart = edgeCnt + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic strayStart(input int c);
        waitCycle(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: timeline expectations from the known start edge, stream data from the scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (nextEdge >= 0 && edgeCnt >= nextEdge) begin
                curEdge  = nextEdge;
                nextEdge = -1;
            end
            cyc = (curEdge >= 0) ? edgeCnt - curEdge : 1000000;
            checkOutput("a_rd_en", a_rd_en, int'(cyc < NN));
            checkOutput("b_rd_en", b_rd_en, int'(cyc < NN));
            checkOutput("sa_en", sa_en, int'(cyc >= 2 && cyc <= NN + 1));
            checkOutput("done", done, int'(cyc == DONECYC));
            checkOutput("busy", busy, int'(cyc <= DONECYC));
            if (sa_en) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stream underflow: sa_en high with no expected beat (edge %0d)", edgeCnt);
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("shift_in_A", shift_in_A, expBeat.a);
                    checkOutput("shift_in_B", shift_in_B, expBeat.b);
                end
            end else begin
                checkOutput("shift_in_A idle", shift_in_A, 0);
                checkOutput("shift_in_B idle", shift_in_B, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int k = 0; k < 2**AW; k++) begin
            memA[k] = DW'($urandom);
            memB[k] = DW'($urandom);
        end
        @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset sa_en", sa_en, 0);
        checkOutput("reset a_rd_en", a_rd_en, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Known pattern; first beat addresses come from A[0][N-1] and B[N-1][0].
        applyStimulus(1);
        checkOutput("first a_rd_addr", a_rd_addr, BASE_A + N - 1);
        checkOutput("first b_rd_addr", b_rd_addr, BASE_B + (N - 1) * N);

`ifdef SA_LOADER_B2B_EN
        strayStart(5);
        waitCycle(25);
        fillMatrices(0);
        pushExpected();
        start     = 1'b1;
        nextEdge  = lastStart + LOADLEN;
        @(negedge clk);
        start = 1'b0;
        strayStart(30);
        lastStart = lastStart + LOADLEN;
`else
        strayStart(5);
        strayStart(30);
`endif

        applyStimulus(1);

        for (int n = 0; n < 3; n++) begin
            waitIdle();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            applyStimulus(0);
        end

`ifndef SA_LOADER_B2B_EN
        // Start held high: one load per pass through IDLE.
        waitIdle();
        fillMatrices(0);
        pushExpected();
        start     = 1'b1;
        nextEdge  = edgeCnt + 1;
        lastStart = edgeCnt + 1;
        waitCycle(LOADLEN);
        fillMatrices(0);
        pushExpected();
        nextEdge  = edgeCnt + 1;
        lastStart = edgeCnt + 1;
        @(negedge clk);
        start = 1'b0;
`endif

        // Asynchronous reset in the middle of READ.
        applyStimulus(0);
        waitCycle(9);
        rst = 1'b1;
        #1;
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset done", done, 0);
        checkOutput("mid reset a_rd_en", a_rd_en, 0);
        checkOutput("mid reset a_rd_addr", a_rd_addr, 0);
        checkOutput("mid reset b_rd_addr", b_rd_addr, 0);
        checkOutput("mid reset sa_en", sa_en, 0);
        checkOutput("mid reset shift_in_A", shift_in_A, 0);
        checkOutput("mid reset shift_in_B", shift_in_B, 0);
        expQ.delete();
        curEdge   = -1;
        nextEdge  = -1;
        lastStart = -1000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        applyStimulus(1);
        checkOutput("restart a_rd_addr", a_rd_addr, BASE_A + N - 1);
        checkOutput("restart b_rd_addr", b_rd_addr, BASE_B + (N - 1) * N);

        waitIdle();
        repeat (5) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
